// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
package fetch_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus, memory and decoder handshake bundle of the fetch unit.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] i_BUS;
    logic             o_PC_OUTPUT_n;
    logic             o_PC_COUNT;
    logic             i_ENABLE;
    logic             i_FLUSH;
    logic [WIDTH-1:0] o_MEM_ADDR;
    logic             o_MEM_READ;
    logic             i_MEM_READY;
    logic [WIDTH-1:0] i_MEM_DATA;
    logic [WIDTH-1:0] o_INSTR;
    logic             i_INSTR_ACCEPT;
    logic             o_INSTR_VALID;
    logic             o_BUSY;
    logic             o_FAULT;

    modport master (
        input  i_BUS, i_ENABLE, i_FLUSH, i_MEM_READY, i_MEM_DATA, i_INSTR_ACCEPT,
        output o_PC_OUTPUT_n, o_PC_COUNT, o_MEM_ADDR, o_MEM_READ,
               o_INSTR, o_INSTR_VALID, o_BUSY, o_FAULT
    );

    modport slave (
        output i_BUS, i_ENABLE, i_FLUSH, i_MEM_READY, i_MEM_DATA, i_INSTR_ACCEPT,
        input  o_PC_OUTPUT_n, o_PC_COUNT, o_MEM_ADDR, o_MEM_READ,
               o_INSTR, o_INSTR_VALID, o_BUSY, o_FAULT
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Saturating wait-cycle counter; expired flags the cycle whose increment reaches LIMIT.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW:0] LIMIT_EXT = (CW + 1)'(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && ({1'b0, count} < LIMIT_EXT)) begin
            count <= count + 1'b1;
        end
    end

    // Looks one increment ahead so the fault lands exactly LIMIT cycles into the wait.
    assign expired = (LIMIT != 0) && enable &&
                     (({1'b0, count} + (CW + 1)'(1)) >= LIMIT_EXT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC onto bus, memory read handshake, hold word for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          i_CLOCK,
    input  logic          i_CLEAR_n,
    fetch_unit_if.master  port
);

    fetch_state_t state;
    logic         timed_out;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (i_CLOCK),
        .rst_n   (i_CLEAR_n),
        .clear   (state == ADDR),
        .enable  (state == WAIT),
        .expired (timed_out)
    );

    // Flush outranks ready/accept; ready outranks a same-cycle timeout; FAULT is terminal.
    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            state              <= IDLE;
            port.o_MEM_ADDR    <= {WIDTH{1'b0}};
            port.o_INSTR       <= {WIDTH{1'b0}};
            port.o_INSTR_VALID <= 1'b0;
            port.o_PC_COUNT    <= 1'b0;
        end else begin
            port.o_PC_COUNT <= 1'b0;
            case (state)
                IDLE: begin
                    if (port.i_ENABLE) state <= ADDR;
                end
                ADDR: begin
                    if (port.i_FLUSH) begin
                        state <= IDLE;
                    end else begin
                        port.o_MEM_ADDR <= port.i_BUS;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (port.i_FLUSH) begin
                        state <= IDLE;
                    end else if (port.i_MEM_READY) begin
                        port.o_INSTR       <= port.i_MEM_DATA;
                        port.o_INSTR_VALID <= 1'b1;
                        port.o_PC_COUNT    <= 1'b1;
                        state              <= HOLD;
                    end else if (timed_out) begin
                        state <= FAULT;
                    end
                end
                HOLD: begin
                    if (port.i_FLUSH) begin
                        port.o_INSTR_VALID <= 1'b0;
                        state              <= IDLE;
                    end else if (port.i_INSTR_ACCEPT) begin
                        port.o_INSTR_VALID <= 1'b0;
                        state              <= port.i_ENABLE ? ADDR : IDLE;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign port.o_PC_OUTPUT_n = (state != ADDR);
    assign port.o_MEM_READ    = (state == WAIT);
    assign port.o_BUSY        = (state != IDLE);
    assign port.o_FAULT       = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    fetch_unit_if #(.WIDTH(WIDTH)) fif ();

    fetch_unit #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_CLOCK   (clk),
        .i_CLEAR_n (clear_n),
        .port      (fif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulse_count = 0;
    bit check_on = 1'b0;

    // Model: where the current fetch stands, tracked as flags plus a wait-cycle tally.
    bit          m_addr_turn = 0;
    bit          m_waiting   = 0;
    bit          m_holding   = 0;
    bit          m_faulted   = 0;
    bit          m_valid     = 0;
    bit          m_count     = 0;
    int          m_waited    = 0;
    logic [31:0] m_addr      = '0;
    logic [31:0] m_instr     = '0;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_addr_turn = 0; m_waiting = 0; m_holding = 0; m_faulted = 0;
            m_valid = 0; m_count = 0; m_waited = 0; m_addr = '0; m_instr = '0;
        end else begin
            m_count = 0;
            if (m_faulted) begin
                m_faulted = 1;
            end else if (m_holding) begin
                if (fif.i_FLUSH || fif.i_INSTR_ACCEPT) begin
                    m_holding   = 0;
                    m_valid     = 0;
                    m_addr_turn = !fif.i_FLUSH && fif.i_ENABLE;
                end
            end else if (m_waiting) begin
                m_waited++;
                if (fif.i_FLUSH) begin
                    m_waiting = 0;
                end else if (fif.i_MEM_READY) begin
                    m_waiting = 0; m_holding = 1; m_valid = 1; m_count = 1;
                    m_instr = fif.i_MEM_DATA;
                end else if (TIMEOUT != 0 && m_waited >= TIMEOUT) begin
                    m_waiting = 0; m_faulted = 1;
                end
            end else if (m_addr_turn) begin
                m_addr_turn = 0;
                if (!fif.i_FLUSH) begin
                    m_addr = fif.i_BUS; m_waiting = 1; m_waited = 0;
                end
            end else if (fif.i_ENABLE) begin
                m_addr_turn = 1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            check_output("pc_output_n", 32'(fif.o_PC_OUTPUT_n), 32'(!m_addr_turn));
            check_output("pc_count",    32'(fif.o_PC_COUNT),    32'(m_count));
            check_output("mem_read",    32'(fif.o_MEM_READ),    32'(m_waiting));
            check_output("mem_addr",    fif.o_MEM_ADDR,         m_addr);
            check_output("instr",       fif.o_INSTR,            m_instr);
            check_output("instr_valid", 32'(fif.o_INSTR_VALID), 32'(m_valid));
            check_output("busy",        32'(fif.o_BUSY),
                         32'(m_addr_turn || m_waiting || m_holding || m_faulted));
            check_output("fault",       32'(fif.o_FAULT),       32'(m_faulted));
            if (fif.o_PC_COUNT === 1'b1) pulse_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit en, input bit flush, input bit ready,
                                  input bit accept);
        fif.i_ENABLE       = en;
        fif.i_FLUSH        = flush;
        fif.i_MEM_READY    = ready;
        fif.i_INSTR_ACCEPT = accept;
    endtask

    // Drops reset between edges and checks every output has already returned to its reset value.
    task automatic reset_pulse();
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check_output("rst pc_output_n", 32'(fif.o_PC_OUTPUT_n), 32'd1);
        check_output("rst pc_count",    32'(fif.o_PC_COUNT),    32'd0);
        check_output("rst mem_read",    32'(fif.o_MEM_READ),    32'd0);
        check_output("rst mem_addr",    fif.o_MEM_ADDR,         32'd0);
        check_output("rst instr",       fif.o_INSTR,            32'd0);
        check_output("rst instr_valid", 32'(fif.o_INSTR_VALID), 32'd0);
        check_output("rst busy",        32'(fif.o_BUSY),        32'd0);
        check_output("rst fault",       32'(fif.o_FAULT),       32'd0);
        tick();
        clear_n = 1'b1;
    endtask

    initial begin
        int ready_pct;
        fif.i_BUS = '0;
        fif.i_MEM_DATA = '0;
        apply_stimulus(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        reset_pulse();
        check_on = 1'b1;

        // Zero-wait fetch of 0xDEADBEEF from 0x40
        fif.i_BUS = 32'h0000_0040;
        fif.i_MEM_DATA = 32'hDEAD_BEEF;
        pulse_count = 0;
        apply_stimulus(1, 0, 1, 0);
        tick();
        fif.i_ENABLE = 0;
        @(negedge clk);
        check_output("t1 addr cycle pc_output_n", 32'(fif.o_PC_OUTPUT_n), 32'd0);
        tick();
        @(negedge clk);
        check_output("t1 wait valid", 32'(fif.o_INSTR_VALID), 32'd0);
        check_output("t1 wait read",  32'(fif.o_MEM_READ),    32'd1);
        tick();
        @(negedge clk);
        check_output("t1 valid",    32'(fif.o_INSTR_VALID), 32'd1);
        check_output("t1 pc_count", 32'(fif.o_PC_COUNT),    32'd1);
        check_output("t1 mem_addr", fif.o_MEM_ADDR,         32'h0000_0040);
        check_output("t1 instr",    fif.o_INSTR,            32'hDEAD_BEEF);
        fif.i_INSTR_ACCEPT = 1;
        tick();
        apply_stimulus(0, 0, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        check_output("t1 pulses", 32'(pulse_count), 32'd1);
        check_output("t1 idle",   32'(fif.o_BUSY),   32'd0);

        // Four wait cycles, then decoder stalls accept for five cycles
        fif.i_BUS = 32'h0000_0100;
        fif.i_MEM_DATA = 32'h1234_5678;
        pulse_count = 0;
        apply_stimulus(1, 0, 0, 0);
        tick();
        fif.i_ENABLE = 0;
        tick();
        repeat (4) tick();
        fif.i_MEM_READY = 1;
        tick();
        fif.i_MEM_READY = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("t2 hold valid",       32'(fif.o_INSTR_VALID), 32'd1);
            check_output("t2 hold instr",       fif.o_INSTR,            32'h1234_5678);
            check_output("t2 hold pc_output_n", 32'(fif.o_PC_OUTPUT_n), 32'd1);
            tick();
        end
        fif.i_INSTR_ACCEPT = 1;
        tick();
        fif.i_INSTR_ACCEPT = 0;
        tick();
        @(negedge clk);
        check_output("t2 pulses", 32'(pulse_count), 32'd1);

        // Flush beats a same-cycle ready
        pulse_count = 0;
        apply_stimulus(1, 0, 0, 0);
        tick();
        fif.i_ENABLE = 0;
        tick();
        apply_stimulus(0, 1, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        @(negedge clk);
        check_output("t3 busy",   32'(fif.o_BUSY),        32'd0);
        check_output("t3 valid",  32'(fif.o_INSTR_VALID), 32'd0);
        check_output("t3 pulses", 32'(pulse_count),       32'd0);

        // Never ready: fault after exactly TIMEOUT wait cycles, flush cannot clear it
        apply_stimulus(1, 0, 0, 0);
        tick();
        fif.i_ENABLE = 0;
        tick();
        repeat (TIMEOUT - 1) tick();
        @(negedge clk);
        check_output("t4 last wait fault", 32'(fif.o_FAULT),    32'd0);
        check_output("t4 last wait read",  32'(fif.o_MEM_READ), 32'd1);
        tick();
        @(negedge clk);
        check_output("t4 fault",      32'(fif.o_FAULT),    32'd1);
        check_output("t4 fault read", 32'(fif.o_MEM_READ), 32'd0);
        apply_stimulus(1, 1, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        check_output("t4 fault after flush", 32'(fif.o_FAULT), 32'd1);
        apply_stimulus(0, 0, 0, 0);
        reset_pulse();

        // Ready on the last permitted wait cycle completes normally
        fif.i_MEM_DATA = 32'hCAFE_F00D;
        apply_stimulus(1, 0, 0, 0);
        tick();
        fif.i_ENABLE = 0;
        tick();
        repeat (TIMEOUT - 1) tick();
        fif.i_MEM_READY = 1;
        tick();
        fif.i_MEM_READY = 0;
        @(negedge clk);
        check_output("t5 fault", 32'(fif.o_FAULT),       32'd0);
        check_output("t5 valid", 32'(fif.o_INSTR_VALID), 32'd1);
        check_output("t5 instr", fif.o_INSTR,            32'hCAFE_F00D);
        fif.i_INSTR_ACCEPT = 1;
        tick();
        fif.i_INSTR_ACCEPT = 0;

        // Asynchronous reset in the middle of a wait
        apply_stimulus(1, 0, 0, 0);
        tick();
        fif.i_ENABLE = 0;
        repeat (2) tick();
        reset_pulse();

        // Randomized traffic with varying memory latency and occasional resets
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_pct = (($urandom % 4) == 0) ? 4 : int'($urandom_range(20, 100));
            if (($urandom % 300) == 0 || (m_faulted && ($urandom % 8) == 0)) begin
                reset_pulse();
            end else begin
                apply_stimulus(($urandom % 4) != 0, ($urandom % 25) == 0,
                               int'($urandom_range(0, 99)) < ready_pct,
                               ($urandom % 3) == 0);
                fif.i_BUS = $urandom;
                fif.i_MEM_DATA = $urandom;
                tick();
            end
        end

        @(negedge clk);
        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
